// File: rtl/dual_line_cache_ctrl.sv
// -----------------------------------------------------------------------------
// dual_line_cache_ctrl
//
// Controller for a two-line instruction cache sitting between the program
// sequencer and a synchronous program ROM (one cycle read latency). Each line
// holds 2**OFF_W words. Every cycle the sequencer's next fetch address is
// compared against both line tags. On a miss a victim line is chosen (an
// invalid line first, otherwise the least-recently-used one), the line is
// streamed from ROM into the cache RAM, and the sequencer is held until the
// line is valid again.
//
// Ports
//   clk            in   system clock, all state on the rising edge
//   sync_reset     in   synchronous active-high reset
//   req_addr       in   next fetch address, held stable while hold=1
//   hold           out  stall request to the sequencer (combinational)
//   rom_address    out  ROM read address, data returns one cycle later
//   cache_wren     out  cache RAM write enable (registered)
//   cache_wrline   out  cache RAM write line index (registered)
//   cache_wroffset out  cache RAM write word offset (registered)
//   cache_rdline   out  cache RAM read line index (registered)
//   cache_rdoffset out  cache RAM read word offset (registered)
//   fill_busy      out  high while a line fill is in progress
//   miss_count     out  saturating miss counter for debug
// -----------------------------------------------------------------------------
module dual_line_cache_ctrl #(
   parameter int ADDR_W = 8,
   parameter int OFF_W  = 5
) (
   input  logic              clk,
   input  logic              sync_reset,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              hold,
   output logic [ADDR_W-1:0] rom_address,
   output logic              cache_wren,
   output logic              cache_wrline,
   output logic [OFF_W-1:0]  cache_wroffset,
   output logic              cache_rdline,
   output logic [OFF_W-1:0]  cache_rdoffset,
   output logic              fill_busy,
   output logic [7:0]        miss_count
);

   localparam int TAG_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {
      ST_LOOKUP = 2'd0,
      ST_FILL   = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   state_e                  state_q,     state_d;
   logic [1:0]              valid_q,     valid_d;
   logic [1:0][TAG_W-1:0]   tag_q,       tag_d;
   logic                    lru_q,       lru_d;
   logic                    fill_line_q, fill_line_d;
   logic [OFF_W-1:0]        cnt_q,       cnt_d;
   logic [7:0]              miss_cnt_q,  miss_cnt_d;
   logic                    wren_q,      wren_d;
   logic                    wrline_q,    wrline_d;
   logic [OFF_W-1:0]        wroffset_q,  wroffset_d;
   logic                    rdline_q,    rdline_d;
   logic [OFF_W-1:0]        rdoffset_q,  rdoffset_d;

   logic [TAG_W-1:0]        req_tag;
   logic                    hit_0;
   logic                    hit_1;
   logic                    hit;
   logic                    hit_idx;
   logic                    victim;
   logic                    stall_req;

   // Victim choice: fill an empty line before evicting anything.
   function automatic logic pick_victim(input logic [1:0] valid, input logic lru);
      logic v;
      if (!valid[0]) begin
         v = 1'b0;
      end else if (!valid[1]) begin
         v = 1'b1;
      end else begin
         v = lru;
      end
      return v;
   endfunction

   assign req_tag = req_addr[ADDR_W-1:OFF_W];
   assign hit_0   = valid_q[0] && (tag_q[0] == req_tag);
   assign hit_1   = valid_q[1] && (tag_q[1] == req_tag);
   assign hit     = hit_0 | hit_1;
   // Line 0 wins if both ever match.
   assign hit_idx = hit_0 ? 1'b0 : 1'b1;
   assign victim  = pick_victim(valid_q, lru_q);

   // The sequencer is never stalled while reset is asserted.
   assign hold           = stall_req & ~sync_reset;
   assign fill_busy      = (state_q == ST_FILL) || (state_q == ST_DRAIN);
   assign cache_wren     = wren_q;
   assign cache_wrline   = wrline_q;
   assign cache_wroffset = wroffset_q;
   assign cache_rdline   = rdline_q;
   assign cache_rdoffset = rdoffset_q;
   assign miss_count     = miss_cnt_q;

   // Next-state, bookkeeping and ROM address generation.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      lru_d       = lru_q;
      fill_line_d = fill_line_q;
      cnt_d       = cnt_q;
      miss_cnt_d  = miss_cnt_q;
      // Write side trails the ROM address by one cycle to absorb ROM latency.
      wren_d      = (state_q == ST_FILL);
      wrline_d    = fill_line_q;
      wroffset_d  = cnt_q;
      rdline_d    = rdline_q;
      rdoffset_d  = req_addr[OFF_W-1:0];
      stall_req   = 1'b0;
      rom_address = {req_tag, {OFF_W{1'b0}}};

      case (state_q)
         ST_LOOKUP: begin
            stall_req = ~hit;
            if (hit) begin
               rdline_d = hit_idx;
               lru_d    = ~hit_idx;
            end else begin
               // Invalidate the victim up front so an aborted fill leaves it invalid.
               valid_d[victim] = 1'b0;
               tag_d[victim]   = req_tag;
               fill_line_d     = victim;
               cnt_d           = {OFF_W{1'b0}};
               miss_cnt_d      = (miss_cnt_q == 8'hFF) ? 8'hFF : (miss_cnt_q + 8'd1);
               state_d         = ST_FILL;
            end
         end
         ST_FILL: begin
            stall_req   = 1'b1;
            rom_address = {tag_q[fill_line_q], cnt_q};
            cnt_d       = cnt_q + {{(OFF_W-1){1'b0}}, 1'b1};
            if (cnt_q == {OFF_W{1'b1}}) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_DRAIN: begin
            // Last ROM word is being written this cycle; line becomes usable next cycle.
            stall_req            = 1'b1;
            rom_address          = {tag_q[fill_line_q], {OFF_W{1'b0}}};
            valid_d[fill_line_q] = 1'b1;
            lru_d                = ~fill_line_q;
            state_d              = ST_LOOKUP;
         end
         default: begin
            stall_req = 1'b0;
            state_d   = ST_LOOKUP;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q     <= ST_LOOKUP;
         valid_q     <= 2'b00;
         tag_q       <= '0;
         lru_q       <= 1'b0;
         fill_line_q <= 1'b0;
         cnt_q       <= {OFF_W{1'b0}};
         miss_cnt_q  <= 8'd0;
         wren_q      <= 1'b0;
         wrline_q    <= 1'b0;
         wroffset_q  <= {OFF_W{1'b0}};
         rdline_q    <= 1'b0;
         rdoffset_q  <= {OFF_W{1'b0}};
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         lru_q       <= lru_d;
         fill_line_q <= fill_line_d;
         cnt_q       <= cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         wren_q      <= wren_d;
         wrline_q    <= wrline_d;
         wroffset_q  <= wroffset_d;
         rdline_q    <= rdline_d;
         rdoffset_q  <= rdoffset_d;
      end
   end

endmodule

// File: tb/tb_dual_line_cache_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for dual_line_cache_ctrl. A reference model tracks the two lines
// (valid/tag), the LRU line and the miss total; during a fill it predicts the
// outputs from the number of cycles elapsed since the miss.
// -----------------------------------------------------------------------------
module tb_dual_line_cache_ctrl;

   logic       clk = 1'b0;
   logic       sync_reset;
   logic [7:0] req_addr;
   logic       hold;
   logic [7:0] rom_address;
   logic       cache_wren;
   logic       cache_wrline;
   logic [4:0] cache_wroffset;
   logic       cache_rdline;
   logic [4:0] cache_rdoffset;
   logic       fill_busy;
   logic [7:0] miss_count;

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   dual_line_cache_ctrl #(.ADDR_W(8), .OFF_W(5)) dut (
      .clk            (clk),
      .sync_reset     (sync_reset),
      .req_addr       (req_addr),
      .hold           (hold),
      .rom_address    (rom_address),
      .cache_wren     (cache_wren),
      .cache_wrline   (cache_wrline),
      .cache_wroffset (cache_wroffset),
      .cache_rdline   (cache_rdline),
      .cache_rdoffset (cache_rdoffset),
      .fill_busy      (fill_busy),
      .miss_count     (miss_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state.
   bit         valid_m [2];
   logic [2:0] tag_m   [2];
   bit         lru_m;
   int         miss_m;
   bit         fill_line_m;
   int         fill_k;        // cycles since the miss, -1 when idle
   logic       exp_rdline;
   logic [4:0] exp_rdoff;
   bit         exp_hold;
   bit         chk_zero;
   int         wren_seen;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      valid_m[0]  = 1'b0;
      valid_m[1]  = 1'b0;
      tag_m[0]    = 3'd0;
      tag_m[1]    = 3'd0;
      lru_m       = 1'b0;
      miss_m      = 0;
      fill_line_m = 1'b0;
      fill_k      = -1;
      exp_rdline  = 1'b0;
      exp_rdoff   = 5'd0;
   endtask

   // One clock cycle: drive inputs, check DUT against the model, advance model.
   task automatic step(input logic rst, input logic [7:0] addr);
      logic [2:0] rtag;
      int         hit_i;
      int         v;
      int         exp_rom;
      @(negedge clk);
      sync_reset = rst;
      req_addr   = addr;
      #1;
      rtag = addr[7:5];
      if (cache_wren === 1'b1) wren_seen++;

      check_val("wren", cache_wren, (fill_k >= 2) ? 1 : 0);
      if (fill_k >= 2) begin
         check_val("wroffset", cache_wroffset, fill_k - 2);
         check_val("wrline", cache_wrline, fill_line_m);
      end
      if (chk_zero) begin
         check_val("wrline_rst", cache_wrline, 0);
         check_val("wroffset_rst", cache_wroffset, 0);
      end
      chk_zero = 1'b0;
      check_val("rdline", cache_rdline, exp_rdline);
      check_val("rdoffset", cache_rdoffset, exp_rdoff);
      check_val("miss_count", miss_count, (miss_m > 255) ? 255 : miss_m);

      if (rst) begin
         check_val("hold_rst", hold, 0);
         model_reset();
         exp_hold = 1'b0;
         chk_zero = 1'b1;
      end else if (fill_k < 0) begin
         hit_i = -1;
         if (valid_m[0] && tag_m[0] == rtag) hit_i = 0;
         else if (valid_m[1] && tag_m[1] == rtag) hit_i = 1;
         check_val("rom_lookup", rom_address, rtag * 32);
         check_val("busy_lookup", fill_busy, 0);
         if (hit_i >= 0) begin
            check_val("hold_hit", hold, 0);
            exp_hold   = 1'b0;
            lru_m      = (hit_i == 0);
            exp_rdline = hit_i[0];
         end else begin
            check_val("hold_miss", hold, 1);
            exp_hold = 1'b1;
            if (!valid_m[0]) v = 0;
            else if (!valid_m[1]) v = 1;
            else v = lru_m;
            valid_m[v]  = 1'b0;
            tag_m[v]    = rtag;
            fill_line_m = v[0];
            miss_m++;
            fill_k = 1;
         end
      end else begin
         exp_rom = tag_m[fill_line_m] * 32 + ((fill_k <= 32) ? fill_k - 1 : 0);
         check_val("hold_fill", hold, 1);
         check_val("busy_fill", fill_busy, 1);
         check_val("rom_fill", rom_address, exp_rom);
         exp_hold = 1'b1;
         if (fill_k == 33) begin
            valid_m[fill_line_m] = 1'b1;
            lru_m  = ~fill_line_m;
            fill_k = -1;
         end else begin
            fill_k++;
         end
      end
      if (!rst) exp_rdoff = addr[4:0];
   endtask

   // Present one fetch address until the DUT releases hold (bounded).
   task automatic fetch(input logic [7:0] addr, output int hcnt);
      int n;
      hcnt = 0;
      n    = 1;
      step(1'b0, addr);
      while (hold === 1'b1 && n < 40) begin
         hcnt++;
         step(1'b0, addr);
         n++;
      end
      if (hold !== 1'b0) begin
         check_val("fetch_hold_release", hold, 0);
      end
   endtask

   initial begin
      int         hc;
      logic [7:0] ra;
      bit         rst_r;

      sync_reset = 1'b1;
      req_addr   = 8'h00;
      model_reset();
      exp_hold   = 1'b0;
      chk_zero   = 1'b1;
      wren_seen  = 0;
      repeat (2) @(posedge clk);
      step(1'b1, 8'h00);

      // Cold miss into line 0.
      wren_seen = 0;
      fetch(8'h00, hc);
      check_val("first_miss_hold", hc, 34);
      check_val("first_miss_wren", wren_seen, 32);
      check_val("first_miss_count", miss_count, 1);

      // Sequential fetches within the line never stall.
      for (int a = 0; a < 32; a++) begin
         fetch(8'(a), hc);
         check_val("seq_stall", hc, 0);
      end

      // Second line fill, then return to line 0.
      fetch(8'h40, hc);
      check_val("fill_line1_hold", hc, 34);
      fetch(8'h05, hc);
      check_val("back_to_line0", hc, 0);

      // LRU eviction: 0x80 replaces line 1, then 0x40 replaces line 0.
      fetch(8'h80, hc);
      check_val("evict_line1", hc, 34);
      fetch(8'h40, hc);
      check_val("evict_line0", hc, 34);
      fetch(8'h80, hc);
      check_val("line1_kept", hc, 0);
      fetch(8'h00, hc);
      check_val("line0_gone", hc, 34);

      // Reset in the middle of a fill (cnt=10), held for two cycles.
      step(1'b0, 8'h60);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h60);
      step(1'b1, 8'h60);
      step(1'b1, 8'h60);
      fetch(8'h60, hc);
      check_val("refill_after_rst", hc, 34);
      fetch(8'h00, hc);
      check_val("both_invalid_after_rst", hc, 34);

      // Random traffic with occasional resets.
      ra = 8'h00;
      for (int i = 0; i < 2000; i++) begin
         if (!exp_hold) ra = 8'($urandom_range(0, 3) * 64 + $urandom_range(0, 31));
         rst_r = ($urandom_range(0, 127) == 0);
         step(rst_r, ra);
      end

      // Miss counter saturation with three tags cycling through two lines.
      step(1'b1, 8'h00);
      for (int i = 0; i < 300; i++) begin
         fetch(8'((i % 3) * 32), hc);
      end
      check_val("miss_saturate", miss_count, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dual_line_cache_ctrl.md
Name: dual_line_cache_ctrl

Overview:
- Controller for a two-line instruction cache between the program sequencer and the synchronous program ROM.
- Each line holds 32 words.
- Every cycle it compares the sequencer's next fetch address against two line tags. On a miss it selects a victim line, streams that line from ROM into the cache RAM, and holds the sequencer until the line is valid.
- It replaces the single-line hold/fill logic with tag/valid/LRU bookkeeping.

Parameters:
- ADDR_W, 8, program address width.
- OFF_W, 5, word-offset width; line size is 2**OFF_W words.
- TAG_W, ADDR_W-OFF_W (3), tag width; derived, not overridable.

Ports:
- clk  input  1  system clock; all state on rising edge.
- sync_reset  input  1  synchronous, active-high reset.
- req_addr  input  ADDR_W  next fetch address (pm_addr) from the sequencer; stable while hold=1.
- hold  output  1  stall request to the sequencer; combinational.
- rom_address  output  ADDR_W  ROM read address; ROM data is valid one cycle later.
- cache_wren  output  1  cache RAM write enable; registered.
- cache_wrline  output  1  line index for the write; registered.
- cache_wroffset  output  OFF_W  word offset for the write; registered.
- cache_rdline  output  1  line index for the read; registered.
- cache_rdoffset  output  OFF_W  word offset for the read; registered from req_addr[OFF_W-1:0].
- fill_busy  output  1  high in FILL and DRAIN states.
- miss_count  output  8  saturating miss counter for debug.

Behaviour:
- State per line i (0, 1): valid[i], tag[i][TAG_W-1:0]. One global lru bit holds the index of the least-recently-used line.
- req_tag is req_addr[ADDR_W-1:OFF_W].
- hit_i = valid[i] && tag[i]==req_tag. hit = hit_0 | hit_1.
- Reset (sync_reset=1, any state):
  - Next state LOOKUP; valid[1:0]=0, tags=0, lru=0.
  - fill counter cnt=0; cache_wren=0, cache_wrline=0, cache_wroffset=0, cache_rdline=0, cache_rdoffset=0; miss_count=0.
  - While sync_reset=1, hold=0 and no miss is recorded.
  - A reset mid-fill aborts the fill immediately. The partially written line stays invalid.
- States: LOOKUP, FILL, DRAIN.
- LOOKUP:
  - hold = ~hit. rom_address = {req_tag, 0}.
  - On hit: cache_rdline <= index of the hitting line; lru <= ~index.
  - On miss:
    - victim = 0 if !valid[0]; else 1 if !valid[1]; else lru.
    - valid[victim] <= 0; tag[victim] <= req_tag; fill_line <= victim; cnt <= 0; miss_count <= miss_count+1, saturating at 255.
    - Go to FILL.
  - cache_rdoffset <= req_addr[OFF_W-1:0] every non-reset cycle.
- FILL:
  - hold=1. rom_address = {tag[fill_line], cnt}. cnt increments each cycle.
  - When cnt==2**OFF_W-1, go to DRAIN.
- Write pipeline, registered, matching the 1-cycle ROM latency:
  - cache_wren <= (state==FILL).
  - cache_wroffset <= cnt.
  - cache_wrline <= fill_line.
  - The final word (offset 31) is written during the DRAIN cycle.
- DRAIN:
  - hold=1. rom_address = {tag[fill_line], 0}.
  - valid[fill_line] <= 1; lru <= ~fill_line.
  - Go to LOOKUP. The next LOOKUP hits because req_addr is held.
- Miss timing: miss detected in cycle t; FILL in t+1..t+32; DRAIN in t+33; hit in LOOKUP at t+34 with hold=0.
  - hold is high for 34 cycles (t..t+33).
  - cache_wren is high for exactly 32 cycles (t+2..t+33), with offsets 0..31 in order.
- Both lines may hold the same tag only transiently; never by design, since a fill only starts on a miss.
- On a tie-free hit, the hit line always wins. hit_0 and hit_1 both true is impossible; if it occurs, line 0 takes priority.
- The counter wraps at 2**OFF_W. No other wrap-around exists.

Test Plan:
- Reset then release with req_addr=0x00 -> 1 miss; fill line 0 with rom_address 0x00..0x1F across 32 cycles; cache_wren for 32 cycles with wrline=0 and offsets 0..31; hold is 34 cycles; miss_count=1.
- Sequential fetch 0x00..0x1F after the fill -> hold stays 0; cache_rdline=0; cache_rdoffset tracks req_addr one cycle later.
- Jump to req_addr=0x40 with line 0 valid -> fill into line 1 (invalid first), rom_address 0x40..0x5F; then jumping back to 0x05 hits line 0 with no stall; lru=1.
- With lines holding tags 0 and 2 and lru=1, request 0x80 -> line 1 evicted (tag 4); a following request to 0x40 misses and evicts line 0.
- Assert sync_reset at cnt=10 of a fill -> next cycle wren=0, hold=0, both valid=0; after release, re-request of the same address refills from offset 0.
- Force 300 misses alternating 0x00/0x20/0x40 -> miss_count saturates at 255.
